muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle execution unit for the RV64M opcode subset. It replaces the single-cycle multiply/divide paths in the execute-stage ALU. It accepts one operation at a time over a valid/ready handshake, computes products in a fixed two-cycle pipeline, and computes quotients and remainders with an iterative restoring radix-2 divider under a small FSM. The result is returned with its tag over a second valid/ready handshake; flush support allows branch-mispredict recovery.

Parameters:
TAG_W, 5, width of the destination tag carried alongside the operation
XLEN, 64, datapath width; only 64 is supported

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation request valid
in_ready  out  1  unit can accept an operation
instruction  in  8  ALU opcode; uses the team encoding: 10-17 for MUL..REMU, 38-42 for MULW..REMUW
rs1  in  64  source operand 1 value
rs2  in  64  source operand 2 value
in_tag  in  TAG_W  destination tag
flush  in  1  kill in-flight or pending-output operation
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  64  final result
out_tag  out  TAG_W  tag of the returned result
out_illegal  out  1  accepted opcode was not an M-extension code
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high, any state, including mid-divide):
  - state=IDLE.
  - in_ready=1; out_valid=0; result=0; out_tag=0; out_illegal=0; busy=0.
  - Iteration counter and operand registers cleared.
- FSM states: IDLE, MUL, DIV, SPECIAL, DONE.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) at cycle T latches opcode, operands and tag, then transitions:
  - opcode 10-13 or 38 -> MUL.
  - opcode 14-17 or 39-42 -> DIV, or SPECIAL if the divide special case applies (see below).
  - any other opcode -> SPECIAL with out_illegal=1 and result=0.
- in_ready=0 in every state except IDLE; one operation is in flight at most.
- MUL (1 cycle): registers the full 128-bit product, then -> DONE, so out_valid is high at T+2.
  - MUL: low 64 bits.
  - MULH: signed x signed, upper 64 bits.
  - MULHSU: signed rs1 x unsigned rs2, upper 64 bits.
  - MULHU: unsigned x unsigned, upper 64 bits.
  - MULW: low 32 bits of rs1[31:0]*rs2[31:0], sign-extended to 64.
- DIV: operands are converted to magnitudes at accept time (signed ops only).
  - One quotient bit per cycle: 64 iterations for 64-bit ops, 32 for W ops (low 32 bits of the operands).
  - Signs are fixed up on exit: quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
  - -> DONE; out_valid is high at T+66 (64-bit) or T+34 (W).
  - W results are the 32-bit quotient/remainder sign-extended to 64, including DIVUW/REMUW.
- SPECIAL (1 cycle) -> DONE; out_valid high at T+2. Special cases:
  - Divide by zero (divisor, or its low 32 bits for W ops, equal to 0): quotient = all ones; remainder = dividend (sign-extended 32-bit dividend for W ops).
  - Signed overflow (dividend = most-negative value, divisor = -1, for DIV/REM/DIVW/REMW): quotient = dividend; remainder = 0.
- DONE: out_valid=1. result, out_tag and out_illegal are held stable until out_valid & out_ready; then -> IDLE, with in_ready=1 on the next cycle.
  - Back-to-back ops: minimum gap is one IDLE cycle (accept is not allowed in DONE).
- flush=1 in any non-IDLE state: -> IDLE next cycle and out_valid=0. The killed result is never presented.
  - flush in IDLE has no effect, and a concurrent in_valid is ignored (no accept that cycle).
  - flush beats out_ready if both are high in DONE.
- busy = (state != IDLE).

Test Plan:
1. MUL: rs1=7, rs2=-3 (0xFFFF_FFFF_FFFF_FFFD), opcode 10 -> out_valid at T+2; result=0xFFFF_FFFF_FFFF_FFEB; in_tag returned on out_tag.
2. MULH and MULHU: rs1=rs2=0xFFFF_FFFF_FFFF_FFFF.
   - MULH -> result 0.
   - MULHU -> result 0xFFFF_FFFF_FFFF_FFFE.
3. DIV: rs1=-20, rs2=3.
   - Quotient -6 (0xFFFF_FFFF_FFFF_FFFA) at T+66.
   - REM gives -2.
   - DIVW with rs1=0x1_0000_0010, rs2=4 -> 4 at T+34.
4. Special cases (both at T+2):
   - DIVU by 0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU by 0 -> rs1.
   - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same operands -> 0.
5. Backpressure: out_ready=0 for 10 cycles after out_valid -> result, out_tag and out_valid stable and in_ready=0; then release -> one-cycle handshake, IDLE.
6. Interruptions:
   - flush at iteration 20 of a DIV -> out_valid never rises; in_ready=1 next cycle; a following MUL completes correctly.
   - reset asserted mid-DIV -> all outputs at reset values next cycle.
   - opcode 0 (ADD) -> out_illegal=1, result=0 at T+2.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response bundle for the multi-cycle RV64M unit.
//   Request : in_valid/in_ready handshake with instruction, rs1, rs2, in_tag; flush kills work.
//   Response: out_valid/out_ready handshake with result, out_tag, out_illegal; busy status.
//   master  : the issuing side (execute stage / testbench).
//   slave   : the muldiv_sequencer itself.
`timescale 1ns/1ps
interface muldiv_sequencer_if #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned XLEN  = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       instruction;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic             busy;

    modport master (
        output in_valid, instruction, rs1, rs2, in_tag, flush, out_ready,
        input  in_ready, out_valid, result, out_tag, out_illegal, busy
    );

    modport slave (
        input  in_valid, instruction, rs1, rs2, in_tag, flush, out_ready,
        output in_ready, out_valid, result, out_tag, out_illegal, busy
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV64M execution unit.
//   Multiplies finish through a one-cycle product register; divides use a restoring radix-2
//   iteration (one quotient bit per cycle, 64 or 32 iterations plus one sign-fixup cycle).
//   Divide-by-zero, signed overflow and non-M opcodes resolve in a single SPECIAL cycle.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : muldiv_sequencer_if.slave (request/response handshakes, flush, busy)
`timescale 1ns/1ps
module muldiv_sequencer #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned XLEN  = 64
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam logic [7:0] OpMul    = 8'd10;
    localparam logic [7:0] OpMulh   = 8'd11;
    localparam logic [7:0] OpMulhsu = 8'd12;
    localparam logic [7:0] OpMulw   = 8'd38;

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StSpecial, StDone} state_e;

    state_e           r_state, w_state_d;
    logic [7:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic             r_illegal;
    logic             r_is_w;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [6:0]       r_cnt;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_result;

    // ---------------- Accept-time decode ----------------
    logic            w_accept;
    logic            w_is_mul, w_is_div, w_is_w, w_div_signed, w_is_rem;
    logic [63:0]     w_a_div, w_b_div, w_a_zx, w_b_zx, w_a_mag, w_b_mag, w_min;
    logic            w_a_neg, w_b_neg, w_div_zero, w_div_ovf, w_special;
    logic [63:0]     w_spec_result;

    always_comb begin
        w_is_mul     = bus.instruction inside {8'd10, 8'd11, 8'd12, 8'd13, 8'd38};
        w_is_div     = bus.instruction inside {[8'd14:8'd17], [8'd39:8'd42]};
        w_is_w       = bus.instruction inside {[8'd38:8'd42]};
        w_div_signed = bus.instruction inside {8'd14, 8'd16, 8'd39, 8'd41};
        w_is_rem     = bus.instruction inside {8'd16, 8'd17, 8'd41, 8'd42};

        // W ops see the sign-extended low word; this also makes the special-case results
        // come out already sign-extended.
        w_a_div = w_is_w ? {{32{bus.rs1[31]}}, bus.rs1[31:0]} : bus.rs1;
        w_b_div = w_is_w ? {{32{bus.rs2[31]}}, bus.rs2[31:0]} : bus.rs2;
        w_a_zx  = w_is_w ? {32'b0, bus.rs1[31:0]} : bus.rs1;
        w_b_zx  = w_is_w ? {32'b0, bus.rs2[31:0]} : bus.rs2;
        w_min   = w_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;

        w_a_neg = w_div_signed & w_a_div[63];
        w_b_neg = w_div_signed & w_b_div[63];
        w_a_mag = w_a_neg ? (64'd0 - w_a_div) : w_a_zx;
        w_b_mag = w_b_neg ? (64'd0 - w_b_div) : w_b_zx;

        w_div_zero = (w_b_div == 64'd0);
        w_div_ovf  = w_div_signed & (w_a_div == w_min) & (w_b_div == '1);
        w_special  = !w_is_mul & (!w_is_div | w_div_zero | w_div_ovf);

        if (!w_is_div) begin
            w_spec_result = 64'd0;
        end else if (w_div_zero) begin
            w_spec_result = w_is_rem ? w_a_div : '1;
        end else begin
            w_spec_result = w_is_rem ? 64'd0 : w_a_div;
        end
    end

    // ---------------- Multiplier ----------------
    logic         w_s1, w_s2;
    logic [127:0] w_prod;
    logic [63:0]  w_mul_result;

    always_comb begin
        w_s1   = (r_op == OpMulh) | (r_op == OpMulhsu);
        w_s2   = (r_op == OpMulh);
        // 65-bit operands cover signed, mixed and unsigned variants with one multiplier.
        w_prod = 128'($signed({w_s1 & r_a[63], r_a}) * $signed({w_s2 & r_b[63], r_b}));
        case (r_op)
            OpMul:   w_mul_result = w_prod[63:0];
            OpMulw:  w_mul_result = {{32{w_prod[31]}}, w_prod[31:0]};
            default: w_mul_result = w_prod[127:64];
        endcase
    end

    // ---------------- Restoring divider step ----------------
    logic [64:0] w_shift, w_diff;
    logic        w_ge, w_div_last;
    logic [63:0] w_q64, w_r64, w_div_result;
    logic [31:0] w_q32, w_r32;

    always_comb begin
        w_shift    = {r_rem, r_quo[63]};
        w_diff     = w_shift - {1'b0, r_b};
        // Partial remainder < 2*divisor, so bit 64 of the 65-bit difference is the borrow.
        w_ge       = !w_diff[64];
        w_div_last = (r_cnt == (r_is_w ? 7'd32 : 7'd64));

        w_q64 = r_neg_q ? (64'd0 - r_quo) : r_quo;
        w_r64 = r_neg_r ? (64'd0 - r_rem) : r_rem;
        w_q32 = r_neg_q ? (32'd0 - r_quo[31:0]) : r_quo[31:0];
        w_r32 = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
        if (r_is_w) begin
            w_div_result = r_is_rem ? {{32{w_r32[31]}}, w_r32} : {{32{w_q32[31]}}, w_q32};
        end else begin
            w_div_result = r_is_rem ? w_r64 : w_q64;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid && !bus.flush) begin
                    w_accept = 1'b1;
                    if (w_is_mul) begin
                        w_state_d = StMul;
                    end else if (w_special) begin
                        w_state_d = StSpecial;
                    end else begin
                        w_state_d = StDiv;
                    end
                end
            end
            StMul:     w_state_d = StDone;
            StDiv:     if (w_div_last) w_state_d = StDone;
            StSpecial: w_state_d = StDone;
            StDone:    if (bus.out_ready) w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
        // Flush overrides everything, including a completing DONE handshake.
        if (bus.flush && (r_state != StIdle)) begin
            w_state_d = StIdle;
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= '0;
            r_tag     <= '0;
            r_illegal <= 1'b0;
            r_is_w    <= 1'b0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_op      <= bus.instruction;
            r_tag     <= bus.in_tag;
            r_illegal <= !(w_is_mul | w_is_div);
            r_is_w    <= w_is_w;
            r_is_rem  <= w_is_rem;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_cnt     <= '0;
            r_rem     <= '0;
            if (w_is_mul) begin
                r_a   <= bus.rs1;
                r_b   <= bus.rs2;
                r_quo <= '0;
            end else begin
                r_a   <= '0;
                r_b   <= w_b_mag;
                // W dividends sit in the top word so the first shift-out is bit 31.
                r_quo <= w_is_w ? {w_a_mag[31:0], 32'b0} : w_a_mag;
            end
            if (w_special) begin
                r_result <= w_spec_result;
            end
        end else if (r_state == StMul) begin
            r_result <= w_mul_result;
        end else if (r_state == StDiv) begin
            if (w_div_last) begin
                r_result <= w_div_result;
            end else begin
                r_rem <= w_ge ? w_diff[63:0] : w_shift[63:0];
                r_quo <= {r_quo[62:0], w_ge};
                r_cnt <= r_cnt + 7'd1;
            end
        end
    end

    assign bus.in_ready    = (r_state == StIdle);
    assign bus.out_valid   = (r_state == StDone);
    assign bus.busy        = (r_state != StIdle);
    assign bus.result      = r_result;
    assign bus.out_tag     = r_tag;
    assign bus.out_illegal = r_illegal;
endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
module tb_muldiv_sequencer;
    localparam int unsigned TAG_W = 5;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    muldiv_sequencer_if #(.TAG_W(TAG_W), .XLEN(64)) bus ();

    muldiv_sequencer #(.TAG_W(TAG_W), .XLEN(64)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] op_list [15] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
                                 8'd38, 8'd39, 8'd40, 8'd41, 8'd42, 8'd0, 8'd99};

    // Reference model: RV64M semantics from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [7:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic signed [127:0] x, y;
        logic [127:0]        p;
        longint              sa, sb, r;
        int                  sa32, sb32, t;
        int unsigned         ua32, ub32, ut;
        sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        r = 0;
        case (op)
            8'd10: r = sa * sb;
            8'd11: begin x = sa; y = sb; p = x * y; r = p[127:64]; end
            8'd12: begin x = sa; y = {64'b0, b}; p = x * y; r = p[127:64]; end
            8'd13: begin x = {64'b0, a}; y = {64'b0, b}; p = x * y; r = p[127:64]; end
            8'd14: if (b == 0) r = -1;
                   else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = sa;
                   else r = sa / sb;
            8'd15: r = (b == 0) ? -1 : longint'(a / b);
            8'd16: if (b == 0) r = sa;
                   else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = 0;
                   else r = sa % sb;
            8'd17: r = (b == 0) ? sa : longint'(a % b);
            8'd38: begin t = sa32 * sb32; r = t; end
            8'd39: begin
                if (sb32 == 0) t = -1;
                else if (ua32 == 32'h8000_0000 && sb32 == -1) t = sa32;
                else t = sa32 / sb32;
                r = t;
            end
            8'd40: begin
                if (ub32 == 0) t = -1;
                else begin ut = ua32 / ub32; t = int'(ut); end
                r = t;
            end
            8'd41: begin
                if (sb32 == 0) t = sa32;
                else if (ua32 == 32'h8000_0000 && sb32 == -1) t = 0;
                else t = sa32 % sb32;
                r = t;
            end
            8'd42: begin
                if (ub32 == 0) t = sa32;
                else begin ut = ua32 % ub32; t = int'(ut); end
                r = t;
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic ref_illegal(input logic [7:0] op);
        return !((op >= 8'd10 && op <= 8'd17) || (op >= 8'd38 && op <= 8'd42));
    endfunction

    // Cycles from the accepting edge to the first cycle with out_valid high.
    function automatic int ref_latency(input logic [7:0] op, input logic [63:0] a,
                                       input logic [63:0] b);
        logic is_div, is_w, sgn;
        is_div = (op >= 8'd14 && op <= 8'd17) || (op >= 8'd39 && op <= 8'd42);
        is_w   = (op >= 8'd39 && op <= 8'd42);
        sgn    = (op == 8'd14) || (op == 8'd16) || (op == 8'd39) || (op == 8'd41);
        if (!is_div) return 2;
        if (is_w) begin
            if (b[31:0] == 0) return 2;
            if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 2;
            return 34;
        end
        if (b == 0) return 2;
        if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 2;
        return 66;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 6))
            0: v = 64'd0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v[31:0] = 32'h8000_0000;
            4: v[31:0] = 32'd0;
            5: v = 64'($urandom_range(0, 100));
            default: ;
        endcase
        return v;
    endfunction

    // Issues one operation, holds off out_ready for 'hold' cycles, then completes it.
    task automatic run_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [TAG_W-1:0] tag, input int hold, input string name);
        logic [63:0] exp_res;
        logic        exp_ill;
        int          exp_lat;
        int          c;
        exp_res = ref_result(op, a, b);
        exp_ill = ref_illegal(op);
        exp_lat = ref_latency(op, a, b);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before_issue: got %b want 1", name, bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.instruction = op; bus.rs1 = a; bus.rs2 = b; bus.in_tag = tag;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        c = 1;
        while (bus.out_valid !== 1'b1 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (c != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d (op %0d)", name, c, exp_lat, op);
        end
        n_checks++;
        if (bus.result !== exp_res) begin
            n_fail++;
            $display("FAIL %s result: got %h want %h (op %0d a %h b %h)", name, bus.result,
                     exp_res, op, a, b);
        end
        n_checks++;
        if (bus.out_tag !== tag) begin
            n_fail++;
            $display("FAIL %s out_tag: got %h want %h", name, bus.out_tag, tag);
        end
        n_checks++;
        if (bus.out_illegal !== exp_ill) begin
            n_fail++;
            $display("FAIL %s out_illegal: got %b want %b", name, bus.out_illegal, exp_ill);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== exp_res ||
                bus.out_tag !== tag) begin
                n_fail++;
                $display("FAIL %s hold_cycle_%0d: got valid %b ready %b result %h tag %h want 1 0 %h %h",
                         name, i, bus.out_valid, bus.in_ready, bus.result, bus.out_tag, exp_res, tag);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_handshake: got valid %b ready %b busy %b want 0 1 0", name,
                     bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 64'd0 ||
            bus.out_tag !== '0 || bus.out_illegal !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got ready %b valid %b result %h tag %h ill %b busy %b want 1 0 0 0 0 0",
                     name, bus.in_ready, bus.out_valid, bus.result, bus.out_tag,
                     bus.out_illegal, bus.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_mul();
        run_op(8'd10, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 0, "mul_7x-3");
        run_op(8'd11, '1, '1, 5'd4, 0, "mulh_m1");
        run_op(8'd13, '1, '1, 5'd5, 0, "mulhu_max");
        run_op(8'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 0, "mulhsu");
        run_op(8'd38, 64'h1234_5678_0001_0000, 64'h0000_0000_0001_0000, 5'd7, 0, "mulw");
    endtask

    task automatic test_div();
        run_op(8'd14, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd8, 0, "div_-20_3");
        run_op(8'd16, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd9, 0, "rem_-20_3");
        run_op(8'd39, 64'h1_0000_0010, 64'd4, 5'd10, 0, "divw");
        run_op(8'd42, 64'h0000_0000_FFFF_FFF7, 64'd10, 5'd11, 0, "remuw");
    endtask

    task automatic test_special();
        run_op(8'd15, 64'h1234, 64'd0, 5'd12, 0, "divu_by_0");
        run_op(8'd17, 64'hDEAD_BEEF_0000_1234, 64'd0, 5'd13, 0, "remu_by_0");
        run_op(8'd14, 64'h8000_0000_0000_0000, '1, 5'd14, 0, "div_ovf");
        run_op(8'd16, 64'h8000_0000_0000_0000, '1, 5'd15, 0, "rem_ovf");
        run_op(8'd41, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 5'd16, 0, "remw_by_0");
    endtask

    task automatic test_illegal();
        run_op(8'd0, 64'd5, 64'd6, 5'd17, 0, "illegal_add");
    endtask

    task automatic test_backpressure();
        run_op(8'd11, 64'h7FFF_0000_1234_5678, 64'hFFFF_FFF0_0000_0001, 5'd18, 10, "backpressure");
    endtask

    task automatic test_flush();
        logic seen;
        // flush in IDLE with a concurrent request: no accept
        bus.in_valid = 1'b1; bus.instruction = 8'd10; bus.rs1 = 64'd2; bus.rs2 = 64'd3;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle: got busy %b ready %b want 0 1", bus.busy, bus.in_ready);
        end
        // flush during a divide
        bus.in_valid = 1'b1; bus.instruction = 8'd14; bus.rs1 = 64'd1000; bus.rs2 = 64'd7;
        bus.in_tag = 5'd19;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_div: got valid %b ready %b busy %b want 0 1 0", bus.out_valid,
                     bus.in_ready, bus.busy);
        end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_output: got out_valid seen %b want 0", seen);
        end
        run_op(8'd10, 64'd123456789, 64'd987654321, 5'd20, 0, "mul_after_flush");
    endtask

    task automatic test_reset_mid_div();
        bus.in_valid = 1'b1; bus.instruction = 8'd15; bus.rs1 = '1; bus.rs2 = 64'd3;
        bus.in_tag = 5'd21;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs("reset_mid_div");
    endtask

    task automatic test_back_to_back();
        run_op(8'd13, 64'hFFFF_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0, 5'd22, 0, "b2b_0");
        run_op(8'd40, 64'h0000_0000_FFFF_FFFF, 64'd16, 5'd23, 0, "b2b_1");
        run_op(8'd10, 64'd0, 64'd99, 5'd24, 0, "b2b_2");
    endtask

    task automatic test_random();
        logic [7:0] op;
        for (int i = 0; i < 40; i++) begin
            op = op_list[$urandom_range(0, 14)];
            run_op(op, rand_operand(), rand_operand(), TAG_W'($urandom),
                   $urandom_range(0, 2), $sformatf("random_%0d", i));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.instruction = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.in_tag = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
